// File: rtl/serdes_rx_pkg.sv
// Shared types and constants for the SerDes receive slicer/packer path.
package serdes_rx_pkg;

    typedef enum logic {SEARCH, LOCKED} rx_align_state_t;

    typedef logic [1:0] pam4_sym_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous FIFO with a valid/ready read side. Pointers carry one extra MSB so that
// a full FIFO can be told apart from an empty one.
module rx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("rx_byte_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    head_idx;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);

    // When empty, point at the slot popped last so the output keeps its previous byte.
    assign head_idx = empty ? (rd_ptr_q[AW-1:0] - IDX_ONE) : rd_ptr_q[AW-1:0];
    assign data_o   = mem_q[head_idx];
    assign valid_o  = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rx_slicer_packer.sv
// Slices equalised samples to NRZ/PAM4 symbols, aligns on SYNC_WORD and packs bytes into a FIFO.
// Define SYMBOL_ERR_CNT_EN to build the symbol-error counter against ref_symbol.
import serdes_rx_pkg::*;

module rx_slicer_packer #(
    parameter int         SIGNAL_RESOLUTION = 8,
    parameter int         BITS_PER_SYMBOL   = 1,
    parameter int         PAM4_THRESH       = 32,
    parameter logic [7:0] SYNC_WORD         = SYNC_WORD_DEFAULT,
    parameter int         FIFO_DEPTH        = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] sample_in,
    input  logic                                sample_valid,
    input  logic                                resync,
    output logic [7:0]                          byte_out,
    output logic                                byte_valid,
    input  logic                                byte_ready,
    output logic                                locked,
    output logic                                overflow,
    output logic [15:0]                         err_count,
    input  logic [1:0]                          ref_symbol
);

    localparam int SR  = SIGNAL_RESOLUTION;
    localparam int BPS = BITS_PER_SYMBOL;
    localparam logic signed [SR-1:0] T_POS    = SR'(PAM4_THRESH);
    localparam logic signed [SR-1:0] T_NEG    = -T_POS;
    localparam logic [2:0]           CNT_STEP = 3'(BPS);
    localparam logic [2:0]           CNT_LAST = 3'(8 - BPS);

    if ((BPS != 1) && (BPS != 2)) begin : g_bad_bps
        $error("rx_slicer_packer: BITS_PER_SYMBOL must be 1 (NRZ) or 2 (PAM4)");
    end

    rx_align_state_t state_q, state_d;
    pam4_sym_t       sym_d, sym_q;
    logic            slice_vld_q;
    logic [7:0]      shift_q, shift_d, shifted;
    logic [2:0]      cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            sym_unused;

    always_comb begin
        sym_d = 2'b00;
        if (BPS == 1) begin
            sym_d = {1'b0, ~sample_in[SR-1]};
        end else if (sample_in < T_NEG) begin
            sym_d = 2'b00;
        end else if (sample_in[SR-1]) begin
            sym_d = 2'b01;
        end else if (sample_in < T_POS) begin
            sym_d = 2'b11;
        end else begin
            sym_d = 2'b10;
        end
    end

    assign shifted    = {shift_q[7-BPS:0], sym_q[BPS-1:0]};
    assign pop        = byte_valid && byte_ready;
    assign sym_unused = ^sym_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // The same shift register serves as the sync window in SEARCH and the byte packer in LOCKED.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        if (resync) begin
            state_d    = SEARCH;
            shift_d    = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (slice_vld_q) begin
            shift_d = shifted;
            case (state_q)
                SEARCH: begin
                    if (shifted == SYNC_WORD) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end
                end
                LOCKED: begin
                    cnt_d = cnt_q + CNT_STEP;
                    if (cnt_q == CNT_LAST) begin
                        push = 1'b1;
                        if (fifo_full && !pop) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_q       <= '0;
            slice_vld_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (sample_valid) begin
                sym_q <= sym_d;
            end
            slice_vld_q <= sample_valid;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (shifted),
        .pop_i   (pop),
        .data_o  (byte_out),
        .valid_o (byte_valid),
        .full_o  (fifo_full)
    );

    assign locked   = (state_q == LOCKED);
    assign overflow = overflow_q;

`ifdef SYMBOL_ERR_CNT_EN
    logic [1:0]  ref_q;
    logic [15:0] err_q;
    logic        ref_unused;

    // ref_symbol is registered alongside the slice so both describe the same sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
            err_q <= '0;
        end else begin
            if (sample_valid) begin
                ref_q <= ref_symbol;
            end
            if (resync) begin
                err_q <= '0;
            end else if (slice_vld_q && (state_q == LOCKED) &&
                         (sym_q[BPS-1:0] != ref_q[BPS-1:0]) && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign err_count  = err_q;
    assign ref_unused = ^ref_q;
`else
    logic ref_unused;

    assign err_count  = 16'h0000;
    assign ref_unused = ^ref_symbol;
`endif

endmodule

// File: tb/tb_rx_slicer_packer.sv
// Self-checking bench for rx_slicer_packer: an NRZ instance (index 0) and a PAM4 instance (index 1).
// Expected bytes, lock, overflow and error counts come from a symbol-level model.
module tb_rx_slicer_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic signed [7:0] sampleIn    [2];
    logic              sampleValid [2];
    logic              resync      [2];
    logic              byteReady   [2];
    logic [1:0]        refSymbol   [2];
    logic [7:0]        byteOut     [2];
    logic              byteValid   [2];
    logic              locked      [2];
    logic              overflow    [2];
    logic [15:0]       errCount    [2];

    int checks   = 0;
    int failures = 0;

    int mLocked [2];
    int mWin    [2];
    int mCnt    [2];
    int mAcc    [2];
    int expOvf  [2];
    int expErr  [2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    rx_slicer_packer #(.SIGNAL_RESOLUTION(8), .BITS_PER_SYMBOL(1), .PAM4_THRESH(32),
                       .SYNC_WORD(8'hA5), .FIFO_DEPTH(4)) dutNrz (
        .clk(clk), .rst(rst), .sample_in(sampleIn[0]), .sample_valid(sampleValid[0]),
        .resync(resync[0]), .byte_out(byteOut[0]), .byte_valid(byteValid[0]),
        .byte_ready(byteReady[0]), .locked(locked[0]), .overflow(overflow[0]),
        .err_count(errCount[0]), .ref_symbol(refSymbol[0]));

    rx_slicer_packer #(.SIGNAL_RESOLUTION(8), .BITS_PER_SYMBOL(2), .PAM4_THRESH(32),
                       .SYNC_WORD(8'hA5), .FIFO_DEPTH(4)) dutPam4 (
        .clk(clk), .rst(rst), .sample_in(sampleIn[1]), .sample_valid(sampleValid[1]),
        .resync(resync[1]), .byte_out(byteOut[1]), .byte_valid(byteValid[1]),
        .byte_ready(byteReady[1]), .locked(locked[1]), .overflow(overflow[1]),
        .err_count(errCount[1]), .ref_symbol(refSymbol[1]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sizeExp(int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void pushExp(int m, logic [7:0] b);
        if (m == 0) q0.push_back(b); else q1.push_back(b);
    endfunction

    function automatic logic [7:0] popExp(int m);
        return (m == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic logic [7:0] headExp(int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void dropLastExp(int m);
        if (m == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    endfunction

    function automatic void modelAlignClear(int m);
        mLocked[m] = 0;
        mWin[m]    = 0;
        mCnt[m]    = 0;
        mAcc[m]    = 0;
        expOvf[m]  = 0;
        expErr[m]  = 0;
    endfunction

    function automatic void modelReset(int m);
        modelAlignClear(m);
        if (m == 0) q0.delete(); else q1.delete();
    endfunction

    function automatic int expectedErr(int m);
`ifdef SYMBOL_ERR_CNT_EN
        return expErr[m];
`else
        return 0;
`endif
    endfunction

    // Byte-level view of the stream: find A5 on symbol boundaries, then cut 8-bit bytes.
    function automatic void modelSym(int m, logic [1:0] sym, logic [1:0] refSym);
        int bps  = m + 1;
        int mask = (1 << bps) - 1;
        int s    = int'(sym) & mask;
        if (mLocked[m] != 0) begin
            if (((int'(sym) ^ int'(refSym)) & mask) != 0) expErr[m]++;
            mAcc[m] = ((mAcc[m] << bps) | s) & 255;
            mCnt[m] += bps;
            if (mCnt[m] == 8) begin
                mCnt[m] = 0;
                if (sizeExp(m) < 4) pushExp(m, 8'(mAcc[m]));
                else expOvf[m] = 1;
            end
        end else begin
            mWin[m] = ((mWin[m] << bps) | s) & 255;
            if (mWin[m] == 'hA5) begin
                mLocked[m] = 1;
                mCnt[m]    = 0;
                mAcc[m]    = 0;
            end
        end
    endfunction

    // Random sample inside the decision region of sym, favouring the region edges.
    function automatic logic signed [7:0] pickSample(int m, logic [1:0] sym);
        int lo, hi, v, r;
        if (m == 0) begin
            if (sym[0]) begin lo = 0; hi = 127; end
            else begin lo = -128; hi = -1; end
        end else begin
            case (sym)
                2'b00:   begin lo = -128; hi = -33; end
                2'b01:   begin lo = -32;  hi = -1;  end
                2'b11:   begin lo = 0;    hi = 31;  end
                default: begin lo = 32;   hi = 127; end
            endcase
        end
        r = int'($urandom_range(0, 2));
        if (r == 0) v = lo;
        else if (r == 1) v = hi;
        else v = lo + int'($urandom_range(0, hi - lo));
        return 8'(v);
    endfunction

    task automatic applyStimulus(int m, logic signed [7:0] sample, logic [1:0] refSym, bit gap);
        sampleIn[m]    = sample;
        refSymbol[m]   = refSym;
        sampleValid[m] = 1'b1;
        tick();
        sampleValid[m] = 1'b0;
        sampleIn[m]    = 8'(int'($urandom_range(0, 255)));
        if (gap) begin
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic sendSym(int m, logic [1:0] sym, logic [1:0] refSym,
                           logic signed [7:0] sample, bit gap);
        modelSym(m, sym, refSym);
        applyStimulus(m, sample, refSym, gap);
    endtask

    task automatic sendRandSym(int m, bit gap);
        logic [1:0] sym;
        sym = (m == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        sendSym(m, sym, sym, pickSample(m, sym), gap);
    endtask

    task automatic sendByte(int m, logic [7:0] b);
        int bps = m + 1;
        logic [1:0] sym;
        for (int i = 8 / bps - 1; i >= 0; i--) begin
            sym = 2'((int'(b) >> (i * bps)) & ((1 << bps) - 1));
            sendSym(m, sym, sym, pickSample(m, sym), 1'b1);
        end
    endtask

    task automatic resyncPulse(int m, bit immediate);
        if (!immediate) begin
            tick();
            tick();
        end
        resync[m] = 1'b1;
        tick();
        resync[m] = 1'b0;
        modelAlignClear(m);
    endtask

    task automatic drain(int m, string name);
        int waitCnt = 0;
        logic [7:0] exp;
        byteReady[m] = 1'b1;
        while (sizeExp(m) > 0 && waitCnt < 60) begin
            if (byteValid[m] === 1'b1) begin
                exp = popExp(m);
                checks++;
                if (byteOut[m] !== exp) begin
                    failures++;
                    $display("[TB] FAIL %s_byte m=%0d: got %h expected %h", name, m, byteOut[m], exp);
                end
            end
            tick();
            waitCnt++;
        end
        byteReady[m] = 1'b0;
        checks++;
        if (sizeExp(m) > 0) begin
            failures++;
            $display("[TB] FAIL %s_timeout m=%0d: %0d bytes still expected", name, m, sizeExp(m));
            if (m == 0) q0.delete(); else q1.delete();
        end
        tick();
        tick();
        checks++;
        if (byteValid[m] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_extra m=%0d: byte_valid=%b expected 0", name, m, byteValid[m]);
        end
    endtask

    task automatic checkLock(int m, string name);
        checks++;
        if (locked[m] !== (mLocked[m] != 0)) begin
            failures++;
            $display("[TB] FAIL %s_locked m=%0d: got %b expected %0d", name, m, locked[m], mLocked[m]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            modelReset(m);
            checks += 5;
            if (byteOut[m] !== 8'h00) begin
                failures++;
                $display("[TB] FAIL reset_byte_out m=%0d: got %h expected 00", m, byteOut[m]);
            end
            if (byteValid[m] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_byte_valid m=%0d: got %b expected 0", m, byteValid[m]);
            end
            if (locked[m] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_locked m=%0d: got %b expected 0", m, locked[m]);
            end
            if (overflow[m] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_overflow m=%0d: got %b expected 0", m, overflow[m]);
            end
            if (errCount[m] !== 16'h0000) begin
                failures++;
                $display("[TB] FAIL reset_err_count m=%0d: got %0d expected 0", m, errCount[m]);
            end
        end
    endtask

    task automatic test_nrz();
        logic [7:0] bits;
        logic [1:0] sym;
        bits = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            sym = {1'b0, bits[i]};
            sendSym(0, sym, sym, bits[i] ? 8'sd40 : -8'sd40, 1'b1);
        end
        tick();
        tick();
        checkLock(0, "nrz_sync");
        checks++;
        if (byteValid[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nrz_sync_output: byte_valid=%b expected 0", byteValid[0]);
        end
        bits = 8'hCA;
        for (int i = 7; i >= 0; i--) begin
            sym = {1'b0, bits[i]};
            sendSym(0, sym, sym, bits[i] ? 8'sd40 : -8'sd40, 1'b1);
        end
        drain(0, "nrz_ca");
        repeat (3) sendByte(0, 8'($urandom_range(0, 255)));
        drain(0, "nrz_rand");
    endtask

    task automatic test_pam4();
        sendSym(1, 2'b10, 2'b10, pickSample(1, 2'b10), 1'b1);
        sendSym(1, 2'b10, 2'b10, pickSample(1, 2'b10), 1'b1);
        sendSym(1, 2'b01, 2'b01, pickSample(1, 2'b01), 1'b1);
        sendSym(1, 2'b01, 2'b01, pickSample(1, 2'b01), 1'b1);
        tick();
        tick();
        checkLock(1, "pam4_sync");
        sendSym(1, 2'b10, 2'b10, 8'sd60,  1'b1);
        sendSym(1, 2'b00, 2'b00, -8'sd60, 1'b1);
        sendSym(1, 2'b11, 2'b11, 8'sd10,  1'b1);
        sendSym(1, 2'b01, 2'b01, -8'sd10, 1'b1);
        tick();
        tick();
        checks++;
        if (byteOut[1] !== 8'h8D) begin
            failures++;
            $display("[TB] FAIL pam4_8d: got %h expected 8d", byteOut[1]);
        end
        drain(1, "pam4_8d");
        repeat (4) sendByte(1, 8'($urandom_range(0, 255)));
        drain(1, "pam4_rand");
    endtask

    task automatic test_overflow();
        logic [7:0] first;
        logic [7:0] b6;
        logic [1:0] sym;
        byteReady[0] = 1'b0;
        repeat (5) sendByte(0, 8'($urandom_range(0, 255)));
        tick();
        tick();
        first = headExp(0);
        checks += 2;
        if (byteValid[0] !== (sizeExp(0) > 0)) begin
            failures++;
            $display("[TB] FAIL ovf_valid: got %b expected %0d", byteValid[0], sizeExp(0) > 0);
        end
        if (overflow[0] !== (expOvf[0] != 0)) begin
            failures++;
            $display("[TB] FAIL ovf_flag: got %b expected %0d", overflow[0], expOvf[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (byteOut[0] !== first) begin
                failures++;
                $display("[TB] FAIL ovf_hold cycle=%0d: got %h expected %h", i, byteOut[0], first);
            end
            tick();
        end
        resyncPulse(0, 1'b0);
        checkLock(0, "ovf_resync");
        checks++;
        if (overflow[0] !== (expOvf[0] != 0)) begin
            failures++;
            $display("[TB] FAIL ovf_resync_clear: got %b expected %0d", overflow[0], expOvf[0]);
        end
        sendByte(0, 8'hA5);
        b6 = 8'($urandom_range(0, 255));
        for (int i = 7; i >= 1; i--) begin
            sym = {1'b0, b6[i]};
            sendSym(0, sym, sym, pickSample(0, sym), 1'b1);
        end
        void'(popExp(0));
        sym = {1'b0, b6[0]};
        sendSym(0, sym, sym, pickSample(0, sym), 1'b0);
        byteReady[0] = 1'b1;
        tick();
        byteReady[0] = 1'b0;
        tick();
        checks++;
        if (overflow[0] !== (expOvf[0] != 0)) begin
            failures++;
            $display("[TB] FAIL ovf_push_pop: got %b expected %0d", overflow[0], expOvf[0]);
        end
        drain(0, "ovf_contents");
    endtask

    task automatic test_resync();
        repeat (3) sendRandSym(0, 1'b1);
        resyncPulse(0, 1'b0);
        checkLock(0, "resync_mid");
        checks++;
        if (overflow[0] !== (expOvf[0] != 0)) begin
            failures++;
            $display("[TB] FAIL resync_mid_overflow: got %b expected %0d", overflow[0], expOvf[0]);
        end
        sendByte(0, 8'hA5);
        tick();
        tick();
        checkLock(0, "resync_relock");
        sendByte(0, 8'($urandom_range(0, 255)));
        drain(0, "resync_aligned");
        repeat (7) sendRandSym(0, 1'b1);
        sendRandSym(0, 1'b0);
        if (sizeExp(0) > 0) dropLastExp(0);
        resyncPulse(0, 1'b1);
        checkLock(0, "resync_coincident");
        drain(0, "resync_coincident");
    endtask

    task automatic test_reset_mid();
        sendByte(0, 8'hA5);
        repeat (3) sendByte(0, 8'($urandom_range(0, 255)));
        repeat (4) sendRandSym(0, 1'b1);
        tick();
        tick();
        checks++;
        if (byteValid[0] !== (sizeExp(0) > 0)) begin
            failures++;
            $display("[TB] FAIL rstmid_queued: got %b expected %0d", byteValid[0], sizeExp(0) > 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset(0);
        modelReset(1);
        checks += 3;
        if (byteValid[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_valid: got %b expected 0", byteValid[0]);
        end
        if (errCount[0] !== 16'(expectedErr(0))) begin
            failures++;
            $display("[TB] FAIL rstmid_err: got %0d expected %0d", errCount[0], expectedErr(0));
        end
        if (overflow[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_overflow: got %b expected 0", overflow[0]);
        end
        checkLock(0, "rstmid");
        sendByte(0, 8'hA5);
        tick();
        tick();
        checkLock(0, "rstmid_relock");
        sendByte(0, 8'($urandom_range(0, 255)));
        drain(0, "rstmid_restart");
    endtask

    task automatic test_err_count();
        logic [9:0] errPos;
        logic [1:0] sym;
        logic [1:0] refSym;
        for (int m = 0; m < 2; m++) begin
            if (mLocked[m] != 0) resyncPulse(m, 1'b0);
            sendByte(m, 8'hA5);
            errPos = '0;
            while ($countones(errPos) < 3) errPos[$urandom_range(0, 9)] = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (m == 0) begin
                    sym    = 2'($urandom_range(0, 1));
                    refSym = {1'($urandom_range(0, 1)), sym[0] ^ errPos[i]};
                end else begin
                    sym    = 2'($urandom_range(0, 3));
                    refSym = errPos[i] ? (sym ^ 2'($urandom_range(1, 3))) : sym;
                end
                sendSym(m, sym, refSym, pickSample(m, sym), 1'b1);
            end
            tick();
            tick();
            checks++;
            if (errCount[m] !== 16'(expectedErr(m))) begin
                failures++;
                $display("[TB] FAIL err_count m=%0d: got %0d expected %0d", m, errCount[m], expectedErr(m));
            end
            drain(m, "err_bytes");
            resyncPulse(m, 1'b0);
            checks++;
            if (errCount[m] !== 16'(expectedErr(m))) begin
                failures++;
                $display("[TB] FAIL err_clear m=%0d: got %0d expected %0d", m, errCount[m], expectedErr(m));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            sampleIn[m]    = '0;
            sampleValid[m] = 1'b0;
            resync[m]      = 1'b0;
            byteReady[m]   = 1'b0;
            refSymbol[m]   = '0;
            modelReset(m);
        end
        test_reset();
        test_nrz();
        test_pam4();
        test_overflow();
        test_resync();
        test_reset_mid();
        test_err_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
